// File: rtl/framing_overlap.sv
// framing_overlap: circular-buffer framer emitting overlapping FRAME_LEN-sample frames,
// consecutive frames starting HOP_LEN samples apart, over a ready/valid output.
module framing_overlap #(
    parameter int unsigned I_BW        = 9,
    parameter int unsigned O_BW        = 16,
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned HOP_LEN     = 128,
    parameter int unsigned BUF_DEPTH   = 384,
    parameter int unsigned CADENCE_CYC = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            last_o,
    output logic            overrun_o
);

    localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned ELEM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned GAP_W  = (CADENCE_CYC > 2) ? $clog2(CADENCE_CYC - 1) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [PTR_W:0]    PTR_DEPTH = (PTR_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W:0]    PTR_HOP   = (PTR_W + 1)'(HOP_LEN);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(BUF_DEPTH);
    localparam logic [OCC_W-1:0]  OCC_FRAME = OCC_W'(FRAME_LEN);
    localparam logic [OCC_W-1:0]  OCC_HOP   = OCC_W'(HOP_LEN);
    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((CADENCE_CYC > 2) ? (CADENCE_CYC - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [I_BW-1:0]   mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  base_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [ELEM_W-1:0] elem_q;
    logic [GAP_W-1:0]  gap_q;
    logic [I_BW-1:0]   rd_data_q;
    logic              overrun_q;

    logic start_frame;
    logic do_fetch;
    logic beat_acc;
    logic frame_rel;
    logic wr_accept;
    logic wr_drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_add_hop(input logic [PTR_W-1:0] p);
        logic [PTR_W:0] s;
        s = {1'b0, p} + PTR_HOP;
        if (s >= PTR_DEPTH) begin
            s = s - PTR_DEPTH;
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        do_fetch    = 1'b0;
        beat_acc    = 1'b0;
        frame_rel   = 1'b0;
        valid_o     = 1'b0;
        last_o      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (occ_q >= OCC_FRAME) begin
                    start_frame = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                do_fetch = 1'b1;
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: begin
                valid_o = 1'b1;
                last_o  = (elem_q == ELEM_LAST);
                if (ready_i) begin
                    beat_acc = 1'b1;
                    if (elem_q == ELEM_LAST) begin
                        frame_rel = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = (CADENCE_CYC > 1) ? ST_GAP : ST_FETCH;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A release in the same cycle frees HOP_LEN slots, so a write at full occupancy still lands.
    assign wr_accept = en_i & valid_i & ((occ_q != OCC_FULL) | frame_rel);
    assign wr_drop   = en_i & valid_i & (occ_q == OCC_FULL) & ~frame_rel;

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            base_ptr_q <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            elem_q     <= '0;
            gap_q      <= '0;
            rd_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else if (!en_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            base_ptr_q <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            elem_q     <= '0;
            gap_q      <= '0;
            rd_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (wr_accept) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (frame_rel) begin
                base_ptr_q <= ptr_add_hop(base_ptr_q);
            end

            unique case ({wr_accept, frame_rel})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_HOP;
                2'b11:   occ_q <= occ_q + OCC_W'(1) - OCC_HOP;
                default: occ_q <= occ_q;
            endcase

            if (wr_drop) begin
                overrun_q <= 1'b1;
            end

            if (start_frame) begin
                rd_ptr_q <= base_ptr_q;
                elem_q   <= '0;
            end else if (beat_acc && !frame_rel) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                elem_q   <= elem_q + ELEM_W'(1);
            end

            if (state_q == ST_GAP) begin
                gap_q <= gap_q + GAP_W'(1);
            end else begin
                gap_q <= '0;
            end

            if (do_fetch) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign data_o    = O_BW'(signed'(rd_data_q));
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_framing_overlap.sv
// tb_framing_overlap: drives two framers (overlapping and non-overlapping hop) with shared
// stimulus and checks every output against a sample-index reference model.
module tb_framing_overlap;

    localparam int I_BW        = 9;
    localparam int O_BW        = 16;
    localparam int FRAME_LEN   = 256;
    localparam int BUF_DEPTH   = 384;
    localparam int CADENCE_CYC = 2;
    localparam int HOP0        = 128;
    localparam int HOP1        = 256;
    localparam int HIST        = 8192;

    logic            clk_i   = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            en_i    = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_i = 1'b0;
    logic [I_BW-1:0] data_i  = '0;

    logic [1:0][O_BW-1:0] data_w;
    logic [1:0]           valid_w;
    logic [1:0]           last_w;
    logic [1:0]           ovr_w;

    framing_overlap #(
        .I_BW(I_BW), .O_BW(O_BW), .FRAME_LEN(FRAME_LEN), .HOP_LEN(HOP0),
        .BUF_DEPTH(BUF_DEPTH), .CADENCE_CYC(CADENCE_CYC)
    ) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
        .data_o(data_w[0]), .valid_o(valid_w[0]), .ready_i(ready_i), .last_o(last_w[0]),
        .overrun_o(ovr_w[0])
    );

    framing_overlap #(
        .I_BW(I_BW), .O_BW(O_BW), .FRAME_LEN(FRAME_LEN), .HOP_LEN(HOP1),
        .BUF_DEPTH(BUF_DEPTH), .CADENCE_CYC(CADENCE_CYC)
    ) u_dut_nov (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
        .data_o(data_w[1]), .valid_o(valid_w[1]), .ready_i(ready_i), .last_o(last_w[1]),
        .overrun_o(ovr_w[1])
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ramp     = 0;
    bit sext_tog = 1'b0;

    // Reference model: every accepted sample is kept by arrival index; frame k element e is
    // sample k*HOP+e since the last clear.
    int          hist [2][HIST];
    int          m_wcnt [2];
    int          m_occ [2];
    int          m_frame [2];
    int          m_elem [2];
    bit          m_ov [2];
    bit          m_hold [2];
    logic [15:0] m_hold_data [2];
    bit          m_first [2];
    int          m_tfill [2];
    int          m_lastacc [2];
    int          frames_done [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int d);
        m_wcnt[d]    = 0;
        m_occ[d]     = 0;
        m_frame[d]   = 0;
        m_elem[d]    = 0;
        m_ov[d]      = 1'b0;
        m_hold[d]    = 1'b0;
        m_first[d]   = 1'b1;
        m_tfill[d]   = -1;
        m_lastacc[d] = -1;
    endtask

    task automatic mon_step(input int d, input bit vo, input bit lo, input logic [15:0] dout,
                            input bit ov);
        int          hop;
        int          occ_pre;
        logic [15:0] e;
        bit          acc;
        bit          rel;
        hop = (d == 0) ? HOP0 : HOP1;
        if (!rst_n_i) begin
            model_clear(d);
            return;
        end
        check_eq($sformatf("overrun%0d", d), ov, m_ov[d]);
        check_eq($sformatf("last_without_valid%0d", d), lo & ~vo, 0);
        if (m_hold[d]) begin
            check_eq($sformatf("hold_valid%0d", d), vo, 1);
            check_eq($sformatf("hold_data%0d", d), dout, m_hold_data[d]);
        end
        if (vo) begin
            check_eq($sformatf("frame_buffered%0d", d), m_occ[d] >= FRAME_LEN, 1);
            e = 16'(hist[d][(m_frame[d] * hop + m_elem[d]) % HIST]);
            check_eq($sformatf("data%0d f%0d e%0d", d, m_frame[d], m_elem[d]), dout, e);
            check_eq($sformatf("last%0d", d), lo, m_elem[d] == FRAME_LEN - 1);
            if (m_first[d]) begin
                check_eq($sformatf("latency%0d", d), cyc - m_tfill[d], 3);
                m_first[d] = 1'b0;
            end
        end
        if (!en_i) begin
            model_clear(d);
            return;
        end
        acc          = vo & ready_i;
        rel          = acc & (m_elem[d] == FRAME_LEN - 1);
        m_hold[d]    = vo & ~ready_i;
        m_hold_data[d] = dout;
        occ_pre      = m_occ[d];
        if (acc) begin
            if (m_lastacc[d] >= 0)
                check_eq($sformatf("cadence%0d", d), (cyc - m_lastacc[d]) >= CADENCE_CYC, 1);
            m_lastacc[d] = cyc;
            if (rel) begin
                m_elem[d] = 0;
                m_frame[d]++;
                m_occ[d] -= hop;
                frames_done[d]++;
            end else begin
                m_elem[d]++;
            end
        end
        if (valid_i) begin
            if (occ_pre < BUF_DEPTH || rel) begin
                hist[d][m_wcnt[d] % HIST] = $signed(data_i);
                m_wcnt[d]++;
                m_occ[d]++;
                if (m_first[d] && m_wcnt[d] == FRAME_LEN) m_tfill[d] = cyc;
            end else begin
                m_ov[d] = 1'b1;
            end
        end
    endtask

    always @(negedge clk_i) begin
        cyc++;
        mon_step(0, valid_w[0], last_w[0], data_w[0], ovr_w[0]);
        mon_step(1, valid_w[1], last_w[1], data_w[1], ovr_w[1]);
    end

    // vm/dm/rm: 0 = off/ramp/low, 1 = on/sign-pattern/high, 2 = random
    task automatic run(input int n, input int vm, input int dm, input int rm);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            case (vm)
                0:       valid_i = 1'b0;
                1:       valid_i = 1'b1;
                default: valid_i = ($urandom_range(9) < 7);
            endcase
            case (dm)
                0:       data_i = I_BW'(ramp);
                1:       data_i = sext_tog ? 9'h100 : 9'h0FF;
                default: data_i = I_BW'($urandom);
            endcase
            if (valid_i) begin
                ramp++;
                sext_tog = ~sext_tog;
            end
            case (rm)
                0:       ready_i = 1'b0;
                1:       ready_i = 1'b1;
                default: ready_i = ($urandom_range(3) != 0);
            endcase
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk_i);
        #1;
        en_i    = 1'b0;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        en_i = 1'b1;
        ramp = 0;
    endtask

    initial begin
        frames_done[0] = 0;
        frames_done[1] = 0;
        repeat (3) @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        @(negedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_valid%0d", d), valid_w[d], 0);
            check_eq($sformatf("rst_last%0d", d), last_w[d], 0);
            check_eq($sformatf("rst_overrun%0d", d), ovr_w[d], 0);
            check_eq($sformatf("rst_data%0d", d), data_w[d], 0);
        end

        // continuous ramp, always ready
        run(1800, 1, 0, 1);
        check_eq("t1_frames0", frames_done[0] >= 2, 1);
        check_eq("t1_frames1", frames_done[1] >= 1, 1);

        // ready stall mid-frame
        pulse_clear();
        run(400, 1, 0, 1);
        run(10, 1, 0, 0);
        run(900, 1, 0, 1);

        // no ready with continuous input until overrun, then drain
        pulse_clear();
        run(400, 1, 0, 0);
        check_eq("t4_overrun0", ovr_w[0], 1);
        check_eq("t4_overrun1", ovr_w[1], 1);
        run(1700, 0, 0, 1);

        // async reset mid-frame while overrun is flagged
        run(200, 1, 0, 1);
        @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("async_valid%0d", d), valid_w[d], 0);
            check_eq($sformatf("async_last%0d", d), last_w[d], 0);
            check_eq($sformatf("async_overrun%0d", d), ovr_w[d], 0);
        end
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        ramp = 1000;
        run(700, 1, 0, 1);

        // sign extension extremes
        pulse_clear();
        run(900, 1, 1, 1);

        // randomized traffic with periodic clears
        for (int k = 0; k < 3; k++) begin
            pulse_clear();
            run(1500, 2, 2, 2);
        end
        check_eq("frames_total0", frames_done[0] >= 8, 1);
        check_eq("frames_total1", frames_done[1] >= 5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
